stage4_fast_pack: RTL

STAGE4_FAST_PACK -- requirements
Module: stage4_fast_pack

---
 rtl/stage4_fast_pack_pkg.sv | 26 ++
 rtl/stage4_byte_sel.sv | 35 +++
 rtl/stage4_fast_pack.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stage4_fast_pack_pkg.sv
// -----------------------------------------------------------------------------
// stage4_fast_pack_pkg
// Shared definitions for the stage-4 fast-message packer.
//   FAST_MESSAGE_BITS : width of one fast-encoded message (left-justified)
//   FAST_LENGTH_BITS  : width of one per-message byte-count field
//   LEN_MIN / LEN_MAX : legal byte-count window; other counts are clamped
//   CNT_BITS          : width of the per-message byte counter
//   state_t           : packer FSM state encoding
// -----------------------------------------------------------------------------
package stage4_fast_pack_pkg;

  localparam int FAST_MESSAGE_BITS = 344;
  localparam int FAST_LENGTH_BITS  = 8;
  localparam int LEN_MIN           = 6;
  localparam int LEN_MAX           = 9;
  localparam int CNT_BITS          = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_MSG1 = 3'd2,
    ST_MSG2 = 3'd3,
    ST_MSG3 = 3'd4
  } state_t;

endpackage

// File: rtl/stage4_byte_sel.sv
// -----------------------------------------------------------------------------
// stage4_byte_sel
// Picks byte k of a left-justified, MSB-first message:
// byte k = msg[FAST_BITS-1-8k -: 8].
// Ports:
//   msg      in  FAST_BITS  registered message
//   idx      in  CNT_BITS   byte index k (0..15)
//   byte_out out 8          selected byte
// -----------------------------------------------------------------------------
module stage4_byte_sel
  import stage4_fast_pack_pkg::*;
#(
  parameter int FAST_BITS = FAST_MESSAGE_BITS
) (
  input  logic [FAST_BITS-1:0] msg,
  input  logic [CNT_BITS-1:0]  idx,
  output logic [7:0]           byte_out
);

  // Every index a 4-bit counter can reach gets a slot, so the lookup is a
  // plain 16:1 mux with no out-of-range case.
  localparam int NUM_SLOTS = 1 << CNT_BITS;

  logic [7:0] byte_arr [NUM_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign byte_arr[gi] = msg[FAST_BITS-1-8*gi -: 8];
    end
  endgenerate

  assign byte_out = byte_arr[idx];

endmodule

// File: rtl/stage4_fast_pack.sv
// -----------------------------------------------------------------------------
// stage4_fast_pack
// Accepts a group of three fast-encoded messages with byte counts and
// serializes it as: one header byte (sum of the effective lengths), then
// L1 bytes of message 1, L2 of message 2, L3 of message 3 (out_last on the
// final byte). Lengths outside 6..9 are clamped and flag len_err (sticky).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid / in_ready               group handshake (ready only in IDLE)
//   message_fast_1..3                 FAST_BITS messages, MSB-first
//   message_fast_length_1..3          LEN_BITS byte counts
//   out_data / out_valid / out_ready  byte stream handshake
//   out_last                          final byte of the group
//   len_err                           sticky illegal-length flag
// -----------------------------------------------------------------------------
module stage4_fast_pack
  import stage4_fast_pack_pkg::*;
#(
  parameter int FAST_BITS = FAST_MESSAGE_BITS,
  parameter int LEN_BITS  = FAST_LENGTH_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FAST_BITS-1:0] message_fast_1,
  input  logic [FAST_BITS-1:0] message_fast_2,
  input  logic [FAST_BITS-1:0] message_fast_3,
  input  logic [LEN_BITS-1:0]  message_fast_length_1,
  input  logic [LEN_BITS-1:0]  message_fast_length_2,
  input  logic [LEN_BITS-1:0]  message_fast_length_3,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 len_err
);

  state_t                state_reg, state_next;
  logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
  logic [FAST_BITS-1:0]  msg_reg [3];
  logic [CNT_BITS-1:0]   len_reg [3];
  logic                  len_err_reg;

  logic [FAST_BITS-1:0]  msg_in  [3];
  logic [LEN_BITS-1:0]   len_in  [3];
  logic [CNT_BITS-1:0]   len_eff [3];
  logic [2:0]            len_low;
  logic [2:0]            len_high;

  logic                  accept;
  logic [FAST_BITS-1:0]  cur_msg;
  logic [CNT_BITS-1:0]   cur_len;
  logic                  last_byte;
  logic [7:0]            hdr_sum;
  logic [7:0]            sel_byte;

  assign msg_in[0] = message_fast_1;
  assign msg_in[1] = message_fast_2;
  assign msg_in[2] = message_fast_3;
  assign len_in[0] = message_fast_length_1;
  assign len_in[1] = message_fast_length_2;
  assign len_in[2] = message_fast_length_3;

  // Clamp each incoming length into the legal window.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      assign len_low[gi]  = len_in[gi] < LEN_BITS'(LEN_MIN);
      assign len_high[gi] = len_in[gi] > LEN_BITS'(LEN_MAX);
      assign len_eff[gi]  = len_low[gi]  ? CNT_BITS'(LEN_MIN) :
                            len_high[gi] ? CNT_BITS'(LEN_MAX) :
                                           len_in[gi][CNT_BITS-1:0];
    end
  endgenerate

  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // Message/length currently being serialized; only meaningful in MSGn.
  always_comb begin
    cur_msg = msg_reg[0];
    cur_len = len_reg[0];
    case (state_reg)
      ST_MSG2: begin
        cur_msg = msg_reg[1];
        cur_len = len_reg[1];
      end
      ST_MSG3: begin
        cur_msg = msg_reg[2];
        cur_len = len_reg[2];
      end
      default: ;
    endcase
  end

  assign last_byte = (cnt_reg == cur_len - CNT_BITS'(1));
  assign hdr_sum   = 8'(len_reg[0]) + 8'(len_reg[1]) + 8'(len_reg[2]);

  stage4_byte_sel #(
    .FAST_BITS (FAST_BITS)
  ) u_byte_sel (
    .msg      (cur_msg),
    .idx      (cnt_reg),
    .byte_out (sel_byte)
  );

  // Next-state / counter logic. Outside IDLE out_valid is always 1, so a
  // handshake is simply out_ready.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_HDR;
          cnt_next   = '0;
        end
      end
      ST_HDR: begin
        if (out_ready) begin
          state_next = ST_MSG1;
          cnt_next   = '0;
        end
      end
      ST_MSG1, ST_MSG2, ST_MSG3: begin
        if (out_ready) begin
          if (last_byte) begin
            cnt_next = '0;
            case (state_reg)
              ST_MSG1: state_next = ST_MSG2;
              ST_MSG2: state_next = ST_MSG3;
              default: state_next = ST_IDLE;
            endcase
          end else begin
            cnt_next = cnt_reg + CNT_BITS'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so they hold during stalls.
  always_comb begin
    out_valid = (state_reg != ST_IDLE);
    out_last  = (state_reg == ST_MSG3) && last_byte;
    out_data  = 8'h00;
    case (state_reg)
      ST_HDR:                    out_data = hdr_sum;
      ST_MSG1, ST_MSG2, ST_MSG3: out_data = sel_byte;
      default:                   out_data = 8'h00;
    endcase
  end

  assign len_err = len_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      len_err_reg <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        msg_reg[i] <= '0;
        len_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          msg_reg[i] <= msg_in[i];
          len_reg[i] <= len_eff[i];
        end
        if (|(len_low | len_high)) begin
          len_err_reg <= 1'b1;
        end
      end
    end
  end

endmodule
